// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the cv32e40x EX-stage divide sequencer.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        DIV_DIVU = 2'b00,
        DIV_DIV  = 2'b01,
        DIV_REMU = 2'b10,
        DIV_REM  = 2'b11
    } div_opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DIVIDE,
        FINISH,
        DONE
    } div_seq_state_e;

    localparam int unsigned DIV_ITERATIONS = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q  = 32'hFFFF_FFFF;

    // Conditional 32-bit two's complement negation (wraps on 0x8000_0000).
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/cv32e40x_div_sequencer_if.sv
// Operand request / result handshake bundle for the divide sequencer.
interface cv32e40x_div_sequencer_if;
    import cv32e40x_pkg::*;

    logic        valid_i;
    logic        ready_o;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    div_opcode_e div_operator_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    modport master (
        output valid_i, op_a_i, op_b_i, div_operator_i, kill_i, ready_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, op_a_i, op_b_i, div_operator_i, kill_i, ready_i,
        output ready_o, valid_o, result_o
    );

endinterface

// File: rtl/cv32e40x_div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring divide,
// early-out for divide-by-zero and signed overflow, result held until accepted.
module cv32e40x_div_sequencer
    import cv32e40x_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    cv32e40x_div_sequencer_if.slave        div_if,
    output logic                           busy_o
);

    div_seq_state_e state_q, state_d;
    div_opcode_e    op_q, op_d;
    logic [31:0]    opa_q, opa_d;
    logic [31:0]    opb_q, opb_d;
    logic [31:0]    dvsr_q, dvsr_d;
    logic [31:0]    quot_q, quot_d;
    logic [31:0]    rem_q, rem_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [31:0]    result_q, result_d;

    logic           is_rem;
    logic           is_signed;
    logic [32:0]    shifted;
    logic [32:0]    diff;

    assign is_rem    = (op_q == DIV_REM) || (op_q == DIV_REMU);
    assign is_signed = (op_q == DIV_DIV) || (op_q == DIV_REM);

    // Trial subtraction is 33 bits wide so the borrow shows up in diff[32].
    assign shifted = {rem_q, quot_q[31]};
    assign diff    = shifted - {1'b0, dvsr_q};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        dvsr_d   = dvsr_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = '0;

        case (state_q)
            IDLE: begin
                if (div_if.valid_i && !div_if.kill_i) begin
                    opa_d   = div_if.op_a_i;
                    opb_d   = div_if.op_b_i;
                    op_d    = div_if.div_operator_i;
                    state_d = INIT;
                end
            end
            INIT: begin
                if (opb_q == '0) begin
                    result_d = is_rem ? opa_q : DIV_BY_ZERO_Q;
                    state_d  = DONE;
                end else if (is_signed && opa_q == 32'h8000_0000 && opb_q == '1) begin
                    result_d = is_rem ? '0 : 32'h8000_0000;
                    state_d  = DONE;
                end else begin
                    quot_d  = neg_if(opa_q, is_signed && opa_q[31]);
                    dvsr_d  = neg_if(opb_q, is_signed && opb_q[31]);
                    rem_d   = '0;
                    cnt_d   = 5'(DIV_ITERATIONS - 1);
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                // A non-negative difference is always < divisor, so 32 bits suffice.
                if (!diff[32]) begin
                    rem_d  = diff[31:0];
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = shifted[31:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == '0) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                result_d = is_rem ? neg_if(rem_q, is_signed && opa_q[31])
                                  : neg_if(quot_q, is_signed && (opa_q[31] ^ opb_q[31]));
                state_d  = DONE;
            end
            DONE: begin
                if (div_if.ready_i) begin
                    state_d = IDLE;
                end else begin
                    result_d = result_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (div_if.kill_i) begin
            state_d  = IDLE;
            result_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= DIV_DIVU;
            opa_q    <= '0;
            opb_q    <= '0;
            dvsr_q   <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            dvsr_q   <= dvsr_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign div_if.ready_o  = (state_q == IDLE);
    assign div_if.valid_o  = (state_q == DONE);
    assign div_if.result_o = result_q;
    assign busy_o          = (state_q != IDLE);

endmodule
